// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding, coin codes
// and the coin-to-nickel value mapping.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] value;
        case (code)
            COIN_NICKEL:  value = 3'd1;
            COIN_DIME:    value = 3'd2;
            COIN_QUARTER: value = 3'd5;
            default:      value = 3'd0;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_stock_ctr.sv
// Product stock counter: reloads to STOCK_MAX on load (which wins over dec),
// counts down on dec, and flags empty in step with the count register.
module vend_stock_ctr #(
    parameter int STOCK_MAX = 8,
    parameter int STOCK_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec,
    input  logic               load,
    output logic [STOCK_W-1:0] count,
    output logic               empty
);

    logic [STOCK_W-1:0] count_reg;
    logic [STOCK_W-1:0] count_next;
    logic               empty_reg;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = STOCK_W'(STOCK_MAX);
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - STOCK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= STOCK_W'(STOCK_MAX);
            empty_reg <= (STOCK_MAX == 0);
        end else begin
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
        end
    end

    assign count = count_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending-machine controller: coin FSM and credit datapath. Credit builds up
// to PRICE, a dispense request is held until acknowledged, then change is paid
// out one nickel per cycle. Stock tracking lives in vend_stock_ctr.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int PRICE     = 3,
    parameter int CREDIT_W  = 4,
    parameter int STOCK_MAX = 8,
    parameter int STOCK_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                restock,
    input  logic                vend_ack,
    output logic                news,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [CREDIT_W-1:0] credit_sum;
    logic                news_reg, news_next;
    logic                change_reg, change_next;
    logic                reject_reg, reject_next;
    logic                coin_valid;
    logic                has_stock;
    logic                stock_dec;
    logic [STOCK_W-1:0]  stock_count;
    logic                stock_empty;

    vend_stock_ctr #(
        .STOCK_MAX (STOCK_MAX),
        .STOCK_W   (STOCK_W)
    ) u_stock (
        .clk   (clk),
        .rst_n (reset),
        .dec   (stock_dec),
        .load  (restock),
        .count (stock_count),
        .empty (stock_empty)
    );

    assign coin_valid = (coin != COIN_NONE);
    assign has_stock  = (stock_count != '0);
    // Credit never exceeds PRICE-1+5, so the sum cannot wrap for legal parameters.
    assign credit_sum = credit_reg + CREDIT_W'(coin_value(coin));

    always_comb begin
        state_next  = state_reg;
        credit_next = credit_reg;
        reject_next = 1'b0;
        stock_dec   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_COLLECT: begin
                if ((state_reg == ST_COLLECT) && cancel) begin
                    // Refund wins; a coin arriving alongside it is bounced.
                    state_next  = ST_CHANGE;
                    reject_next = coin_valid;
                end else if (coin_valid) begin
                    if (has_stock) begin
                        credit_next = credit_sum;
                        state_next  = (credit_sum >= PRICE_C) ? ST_VEND : ST_COLLECT;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                reject_next = coin_valid;
                if (vend_ack) begin
                    credit_next = credit_reg - PRICE_C;
                    stock_dec   = 1'b1;
                    state_next  = (credit_reg == PRICE_C) ? ST_IDLE : ST_CHANGE;
                end
            end
            ST_CHANGE: begin
                reject_next = coin_valid;
                if (credit_reg <= CREDIT_W'(1)) begin
                    credit_next = '0;
                    state_next  = ST_IDLE;
                end else begin
                    credit_next = credit_reg - CREDIT_W'(1);
                end
            end
            default: begin
                state_next  = ST_IDLE;
                credit_next = '0;
            end
        endcase
        news_next   = (state_next == ST_VEND);
        change_next = (state_next == ST_CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            credit_reg <= '0;
            news_reg   <= 1'b0;
            change_reg <= 1'b0;
            reject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            credit_reg <= credit_next;
            news_reg   <= news_next;
            change_reg <= change_next;
            reject_reg <= reject_next;
        end
    end

    assign news          = news_reg;
    assign change_nickel = change_reg;
    assign coin_reject   = reject_reg;
    assign sold_out      = stock_empty;
    assign credit        = credit_reg;

endmodule
